// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] first_operand,
    input  logic [WIDTH-1:0] second_operand,
    input  logic [3:0]       oper_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             hisel_q, hisel_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] div_hi, div_lo;
    logic             last;

    assign shamt = second_operand[SHW-1:0];

    always_comb begin
        simple = '0;
        case (oper_sel)
            4'b0000: simple = first_operand + second_operand;
            4'b0001: simple = first_operand << shamt;
            4'b0010: simple = first_operand - second_operand;
            4'b0011: simple = {{(WIDTH-1){1'b0}},
                               $signed(first_operand) < $signed(second_operand)};
            4'b0100: simple = first_operand ^ second_operand;
            4'b0101: simple = first_operand >> shamt;
            4'b0110: simple = first_operand | second_operand;
            4'b0111: simple = first_operand & second_operand;
            4'b1000: simple = {{(WIDTH-1){1'b0}}, first_operand < second_operand};
            4'b1101: simple = $signed(first_operand) >>> shamt;
            default: simple = '0;
        endcase
    end

    // Multiply: hi accumulates the product top, lo holds the shrinking multiplier.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign shifted = {hi_q, lo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, opnd_q};
    assign div_hi  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign div_lo  = {lo_q[WIDTH-2:0], ~trial[WIDTH]};

    assign last = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        hisel_d = hisel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    hisel_d = (oper_sel == 4'b1011) || (oper_sel == 4'b1110);
                    case (oper_sel)
                        4'b1010, 4'b1011: begin
                            state_d = MUL;
                            opnd_d  = first_operand;
                            lo_d    = second_operand;
                        end
                        4'b1100, 4'b1110: begin
                            state_d = DIV;
                            opnd_d  = second_operand;
                            lo_d    = first_operand;
                        end
                        default: begin
                            state_d = DONE;
                            res_d   = simple;
                        end
                    endcase
                end
            end
            MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    res_d   = hisel_q ? mul_hi : mul_lo;
                end
            end
            DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    res_d   = hisel_q ? div_hi : div_lo;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            hisel_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            hisel_q <= hisel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign alu_out   = res_q;
    assign zero_flag = (res_q == '0);
    assign sign_flag = res_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for every opcode plus
// backpressure and mid-divide reset sequences.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] first_operand;
    logic [W-1:0] second_operand;
    logic [3:0]   oper_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         zero_flag;
    logic         sign_flag;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .first_operand  (first_operand),
        .second_operand (second_operand),
        .oper_sel       (oper_sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_out        (alu_out),
        .zero_flag      (zero_flag),
        .sign_flag      (sign_flag),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int elat);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid       = 1'b1;
        oper_sel       = op;
        first_operand  = a;
        second_operand = b;
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        first_operand  = $urandom;
        second_operand = $urandom;
        oper_sel       = 4'($urandom);
        out_ready      = 1'b1;
        lat     = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " alu_out"}, 64'(alu_out), 64'(exp));
        chk({nm, " zero_flag"}, 64'(zero_flag), 64'(exp == '0));
        chk({nm, " sign_flag"}, 64'(sign_flag), 64'(exp[W-1]));
        chk({nm, " busy_done"}, 64'(busy), 64'd0);
        if (elat > 1) chk({nm, " busy_iter"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, " release"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        int seen_valid;

        vecs[0]  = '{"add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 1};
        vecs[1]  = '{"sub", 4'b0010, 32'd5, 32'd7, 32'hFFFFFFFE, 1};
        vecs[2]  = '{"sll_33", 4'b0001, 32'h1, 32'd33, 32'h2, 1};
        vecs[3]  = '{"srl", 4'b0101, 32'h80000000, 32'd4, 32'h08000000, 1};
        vecs[4]  = '{"sra", 4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 1};
        vecs[5]  = '{"slt", 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h1, 1};
        vecs[6]  = '{"sltu", 4'b1000, 32'hFFFFFFFF, 32'h1, 32'h0, 1};
        vecs[7]  = '{"xor", 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
        vecs[8]  = '{"or", 4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1};
        vecs[9]  = '{"and", 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
        vecs[10] = '{"illegal9", 4'b1001, 32'h1234, 32'h5678, 32'h0, 1};
        vecs[11] = '{"illegalF", 4'b1111, 32'h1234, 32'h5678, 32'h0, 1};
        vecs[12] = '{"mul_ones", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33};
        vecs[13] = '{"mulhu_ones", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[14] = '{"mul_dec", 4'b1010, 32'd12345, 32'd1000, 32'h00BC5EA8, 33};
        vecs[15] = '{"divu", 4'b1100, 32'd100, 32'd7, 32'd14, 33};
        vecs[16] = '{"remu", 4'b1110, 32'd100, 32'd7, 32'd2, 33};
        vecs[17] = '{"divu_zero", 4'b1100, 32'd5, 32'd0, 32'hFFFFFFFF, 33};
        vecs[18] = '{"slt_neg", 4'b0011, 32'h1, 32'h80000000, 32'h0, 1};
        vecs[19] = '{"remu_zero", 4'b1110, 32'd5, 32'd0, 32'd5, 33};

        rst            = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        first_operand  = '0;
        second_operand = '0;
        oper_sel       = '0;
        #1;
        chk("reset outputs", 64'({out_valid, busy, zero_flag, sign_flag}), 64'b0010);
        chk("reset alu_out", 64'(alu_out), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 20; i++)
            run(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Backpressure: result held while consumer stalls; new request ignored.
        @(negedge clk);
        in_valid = 1'b1; oper_sel = 4'b0000; first_operand = 32'd2; second_operand = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp first result", 64'({out_valid, alu_out}), {31'd0, 1'b1, 32'd5});
        @(negedge clk);
        in_valid = 1'b1; oper_sel = 4'b0010; first_operand = 32'd100; second_operand = 32'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold %0d", c), 64'({out_valid, in_ready, alu_out}),
                {30'd0, 2'b10, 32'd5});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release", 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk);
        #1;
        chk("bp not queued", 64'({out_valid, in_ready}), 64'b01);

        // Reset during divide iteration 10.
        @(negedge clk);
        in_valid = 1'b1; oper_sel = 4'b1100; first_operand = 32'd100; second_operand = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid div busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("async rst flags", 64'({out_valid, busy, zero_flag, sign_flag, in_ready}),
            64'b00101);
        chk("async rst alu_out", 64'(alu_out), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        out_ready = 1'b0;
        chk("no valid after abort", 64'(seen_valid), 64'd0);
        run("post rst add", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL provide localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, the operation request is valid.
REQ-006 SHALL have port in_ready, output, 1, the block can accept a request.
REQ-007 SHALL have port first_operand, input, WIDTH, operand A.
REQ-008 SHALL have port second_operand, input, WIDTH, operand B.
REQ-009 SHALL have port oper_sel, input, 4, operation select per REQ-016.
REQ-010 SHALL have port out_valid, output, 1, the result is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port alu_out, output, WIDTH, the registered result.
REQ-013 SHALL have port zero_flag, output, 1, set when alu_out equals 0.
REQ-014 SHALL have port sign_flag, output, 1, equal to alu_out[WIDTH-1].
REQ-015 SHALL have port busy, output, 1, high in states MUL or DIV.

Function
REQ-016 Encoding SHALL be: 0000 add; 0001 sll; 0010 sub; 0011 slt (signed); 0100 xor; 0101 srl; 0110 or; 0111 and; 1000 sltu; 1101 sra; 1010 mul (low WIDTH bits); 1011 mulhu (high WIDTH bits, unsigned); 1100 divu; 1110 remu; all other codes give result 0 with single-cycle timing.
REQ-017 Add/sub SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-018 Shifts SHALL use only second_operand[SHW-1:0] as the shift amount; upper bits are ignored.
REQ-019 slt/sltu SHALL return 1 or 0, zero-extended to WIDTH.
REQ-020 FSM states SHALL be IDLE, MUL, DIV, DONE; IDLE is the reset state.
REQ-021 Handshake: in_ready SHALL equal (state==IDLE); a request is accepted on a rising edge with in_valid && in_ready, and operands and oper_sel are captured at that edge.
REQ-022 Single-cycle ops SHALL go IDLE->DONE at acceptance, with out_valid high in the next cycle (latency 1).
REQ-023 mul/mulhu SHALL use an iterative shift-add multiplier: IDLE->MUL, WIDTH iterations, then ->DONE; out_valid SHALL rise WIDTH+1 edges after acceptance.
REQ-024 divu/remu SHALL use an iterative restoring divider: IDLE->DIV, WIDTH iterations, then ->DONE; latency SHALL be WIDTH+1 edges.
REQ-025 Divide by zero SHALL still take the full latency and return quotient all-ones and remainder = first_operand.
REQ-026 In DONE, out_valid SHALL be 1, and alu_out and the flags SHALL be held stable until out_ready is high, which moves the FSM DONE->IDLE on that edge.
REQ-027 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE; no request is queued.
REQ-028 Flags SHALL be derived from the registered alu_out and be valid whenever out_valid is high.
REQ-029 Changes on the input ports after acceptance SHALL NOT affect the result in progress.

Reset
REQ-030 On rst=1, immediately and regardless of state: state=IDLE, alu_out=0, out_valid=0, busy=0, sign_flag=0, zero_flag=1, and the iteration counter and partial registers are cleared.
REQ-031 Reset mid-MUL or mid-DIV SHALL abandon the operation; no out_valid is produced for it.
REQ-032 After rst falls, in_ready SHALL be 1 in the first cycle.

Verification
REQ-033 WIDTH=32, add 0xFFFFFFFF+0x1 -> out_valid 1 cycle after accept, alu_out=0, zero_flag=1, sign_flag=0.
REQ-034 sll 0x1 by second_operand=33 -> alu_out=0x2; sra 0x80000000 by 4 -> 0xF8000000, sign_flag=1.
REQ-035 mulhu 0xFFFFFFFF x 0xFFFFFFFF -> alu_out=0xFFFFFFFE after 33 edges; mul on the same operands -> 0x00000001.
REQ-036 divu 100/7 -> 14; remu 100/7 -> 2; divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; each with latency 33 and busy high throughout the iterations.
REQ-037 Backpressure: out_ready=0 for 5 cycles after result -> alu_out stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next edge.
REQ-038 rst asserted at iteration 10 of divu -> all outputs reach reset values asynchronously, no out_valid; a following add 2+3 returns 5.
